// File: rtl/nsadd_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nsadd_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} nsadd_state_t;

    localparam int NIBBLE_W = 4;

    // Floors at 1 so a single-nibble build still gets a legal counter.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca4.sv
// Combinational 4-bit ripple-carry adder slice.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_add.sv
// Nibble-serial W-bit adder driving one rca4, LS nibble first, carry registered.
// Optional signed-overflow output enabled by defining NSADD_OVF_EN.
module nibble_serial_add
    import nsadd_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIBBLE_W * NIBBLES,
    localparam int CW     = clog2(NIBBLES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_co,
`ifdef NSADD_OVF_EN
    output logic         busy,
    output logic         ovf
`else
    output logic         busy
`endif
);

    nsadd_state_t  state_q;
    logic [W-1:0]  a_q, b_q, s_q;
    logic [W-1:0]  s_d;
    logic          c_q, co_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    nib_s;
    logic          nib_co;
`ifdef NSADD_OVF_EN
    logic          sa_q, sb_q, ovf_q;
`endif

    rca4 u_rca4 (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (c_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // New nibble enters at the top; after NIBBLES shifts s_q holds the full sum.
    assign s_d = (s_q >> NIBBLE_W) | (W'(nib_s) << (W - NIBBLE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef NSADD_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        c_q     <= in_ci;
                        cnt_q   <= '0;
`ifdef NSADD_OVF_EN
                        sa_q    <= in_a[W-1];
                        sb_q    <= in_b[W-1];
`endif
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    s_q   <= s_d;
                    a_q   <= a_q >> NIBBLE_W;
                    b_q   <= b_q >> NIBBLE_W;
                    c_q   <= nib_co;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NIBBLES - 1)) begin
                        co_q    <= nib_co;
`ifdef NSADD_OVF_EN
                        // nib_s[3] is the sum's sign bit on the last nibble.
                        ovf_q   <= (sa_q == sb_q) && (nib_s[3] != sa_q);
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_s     = s_q;
    assign out_co    = co_q;
`ifdef NSADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// Directed bench for nibble_serial_add: a NIBBLES=4 and a NIBBLES=1 instance.
module tb_nibble_serial_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        iv [2];
    logic [15:0] ia [2];
    logic [15:0] ib [2];
    logic        ic [2];
    logic        ordy [2];
    logic        ir [2];
    logic        ov [2];
    logic        oc [2];
    logic        bz [2];
    logic [15:0] os0;
    logic [3:0]  os1;
    logic        ovf0, ovf1;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_add #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0]), .in_b(ib[0]), .in_ci(ic[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_s(os0), .out_co(oc[0]),
`ifdef NSADD_OVF_EN
        .busy(bz[0]), .ovf(ovf0)
`else
        .busy(bz[0])
`endif
    );

    nibble_serial_add #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1][3:0]), .in_b(ib[1][3:0]), .in_ci(ic[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_s(os1), .out_co(oc[1]),
`ifdef NSADD_OVF_EN
        .busy(bz[1]), .ovf(ovf1)
`else
        .busy(bz[1])
`endif
    );

`ifndef NSADD_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    function automatic logic [15:0] s_of(input int k);
        return (k == 0) ? os0 : {12'h0, os1};
    endfunction

    function automatic int nib_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int k, output int n);
        n = 0;
        while (!ov[k] && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic eco,
                          input logic eovf);
        int n;
        ia[k] = a; ib[k] = b; ic[k] = ci; iv[k] = 1'b1;
        step();
        iv[k] = 1'b0;
        chk("accept_busy", 32'(bz[k]), 32'd1);
        wait_ov(k, n);
        chk("latency", 32'(n), 32'(nib_of(k)));
        chk("out_s", 32'(s_of(k)), 32'(es));
        chk("out_co", 32'(oc[k]), 32'(eco));
`ifdef NSADD_OVF_EN
        chk("ovf", 32'(ovf0), 32'(eovf));
`else
        if (eovf) ;
`endif
    endtask

    task automatic release_op(input int k);
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        chk("back_idle_ready", 32'(ir[k]), 32'd1);
        chk("back_idle_valid", 32'(ov[k]), 32'd0);
    endtask

    task automatic stream(input int k);
        int w, n, last;
        logic [15:0] a, b, msk;
        logic        ci;
        logic [16:0] exp, obs;
        w = 4 * nib_of(k);
        msk = 16'((32'h1 << w) - 1);
        last = 0;
        ordy[k] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom) & msk;
            b = 16'($urandom) & msk;
            ci = 1'($urandom);
            exp = 17'(a) + 17'(b) + 17'(ci);
            ia[k] = a; ib[k] = b; ic[k] = ci; iv[k] = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while (!bz[k] && n < 20);
            iv[k] = 1'b0;
            chk("stream_accept", 32'(bz[k]), 32'd1);
            if (i > 0) chk("stream_interval", 32'(cyc - last), 32'(nib_of(k) + 2));
            last = cyc;
            wait_ov(k, n);
            obs = (17'(oc[k]) << w) | 17'(s_of(k));
            chk("stream_sum", 32'(obs), 32'(exp));
        end
        step();
        ordy[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; ic[k] = 1'b0; ordy[k] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_s", 32'(os0), 32'd0);
        chk("rst_out_co", 32'(oc[0]), 32'd0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run_op(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        release_op(0);
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        release_op(0);
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        release_op(0);

        // Consumer stalls: result must hold and new requests must be ignored.
        run_op(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        hs = os0;
        hc = oc[0];
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0];
            ia[0] = 16'($urandom);
            step();
            chk("hold_s", 32'(os0), 32'(hs));
            chk("hold_co", 32'(oc[0]), 32'(hc));
            chk("hold_in_ready", 32'(ir[0]), 32'd0);
            chk("hold_valid", 32'(ov[0]), 32'd1);
        end
        iv[0] = 1'b0;
        release_op(0);

        // Reset during the second ADD cycle.
        ia[0] = 16'hABCD; ib[0] = 16'h1111; ic[0] = 1'b1; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_out_s", 32'(os0), 32'd0);
        chk("midrst_out_co", 32'(oc[0]), 32'd0);
        chk("midrst_busy", 32'(bz[0]), 32'd0);
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_ovf", 32'(ovf0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op(0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        release_op(0);

        stream(0);
        stream(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
